// File: rtl/aes_pkg.sv
// Shared AES constants and the round-key store FSM state type.
package aes_pkg;

  localparam int unsigned AES_KEY_W      = 128;
  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_NUM_KEYS   = AES_NUM_ROUNDS + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } rks_state_t;

endpackage

// File: rtl/rks_regfile.sv
// Round-key storage: one write port, one registered read port, no reset on the array.
module rks_regfile #(
  parameter int unsigned KEY_W    = 128,
  parameter int unsigned NUM_KEYS = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic             re,
  input  logic [3:0]       raddr,
  output logic [KEY_W-1:0] rdata
);

  logic [KEY_W-1:0] mem [NUM_KEYS];
  logic [KEY_W-1:0] rdata_q;

  // Write port; callers only present in-range addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to the same slot is not visible until next cycle.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/round_key_store.sv
// Round-key store sitting behind the AES key expansion: captures keys 0..NUM_ROUNDS in strict
// order, then serves single-cycle-latency reads.
// Optional macro ROUND_KEY_STORE_DEC_ORDER_EN adds rd_dec for reverse-order (decrypt) reads.
module round_key_store
  import aes_pkg::*;
#(
  parameter int unsigned KEY_W      = AES_KEY_W,
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_valid,
  input  logic [KEY_W-1:0] init_key,
  input  logic [KEY_W-1:0] exp_key,
  input  logic [3:0]       exp_addr,
  input  logic             exp_loaded,
  input  logic             rd_req,
  input  logic [3:0]       rd_addr,
`ifdef ROUND_KEY_STORE_DEC_ORDER_EN
  input  logic             rd_dec,
`endif
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic             keys_ready,
  output logic             err
);

  localparam int unsigned NumKeys = NUM_ROUNDS + 1;
  localparam logic [3:0]  LastIdx = 4'(NUM_ROUNDS);

  rks_state_t       state_q, state_d;
  logic [3:0]       exp_next_q, exp_next_d;
  logic             err_q, err_d;
  logic             rd_valid_q;
  logic             rd_zero_q;

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [KEY_W-1:0] wr_data;
  logic             proto_err;

  logic             rd_ok;
  logic [3:0]       rd_slot;
  logic [KEY_W-1:0] rf_rdata;

  // Write decode and next-state: init_valid wins over any expansion write in the same cycle.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = exp_key;
    state_d    = state_q;
    exp_next_d = exp_next_q;
    proto_err  = 1'b0;
    if (init_valid) begin
      wr_en      = 1'b1;
      wr_addr    = '0;
      wr_data    = init_key;
      state_d    = FILLING;
      exp_next_d = 4'd1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (exp_addr != '0) proto_err = 1'b1;
        end
        FILLING: begin
          if (exp_addr != '0) begin
            if (exp_addr == exp_next_q) begin
              wr_en      = 1'b1;
              wr_addr    = exp_addr;
              exp_next_d = 4'(exp_next_q + 4'd1);
              if (exp_addr == LastIdx) state_d = READY;
            end else begin
              // Skip, repeat or out-of-range index: the set is unusable, start over.
              proto_err  = 1'b1;
              state_d    = EMPTY;
              exp_next_d = '0;
            end
          end
          if (exp_loaded) proto_err = 1'b1;
        end
        READY: begin
          if (exp_addr != '0) proto_err = 1'b1;
        end
        default: begin
          state_d    = EMPTY;
          exp_next_d = '0;
        end
      endcase
    end
  end

  // Read decode: range check is on the raw address, before any reverse mapping.
  always_comb begin
    rd_ok = rd_req && (state_q == READY) && (rd_addr <= LastIdx);
`ifdef ROUND_KEY_STORE_DEC_ORDER_EN
    rd_slot = rd_dec ? 4'(LastIdx - rd_addr) : rd_addr;
`else
    rd_slot = rd_addr;
`endif
    err_d = (init_valid ? 1'b0 : err_q) | proto_err | (rd_req & ~rd_ok);
  end

  // FSM, expected-index counter, sticky error and read-response flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      exp_next_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      exp_next_q <= exp_next_d;
      err_q      <= err_d;
      rd_valid_q <= rd_req;
      // rd_key holds between reads, so only update the zero mask on a request.
      if (rd_req) rd_zero_q <= ~rd_ok;
    end
  end

  rks_regfile #(
    .KEY_W    (KEY_W),
    .NUM_KEYS (NumKeys)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_ok),
    .raddr (rd_slot),
    .rdata (rf_rdata)
  );

  assign rd_valid   = rd_valid_q;
  assign rd_key     = rd_zero_q ? '0 : rf_rdata;
  assign keys_ready = (state_q == READY);
  assign err        = err_q;

endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store using the FIPS-197 example key schedule.
module tb_round_key_store;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init_valid;
  logic [127:0] init_key;
  logic [127:0] exp_key;
  logic [3:0]   exp_addr;
  logic         exp_loaded;
  logic         rd_req;
  logic [3:0]   rd_addr;
`ifdef ROUND_KEY_STORE_DEC_ORDER_EN
  logic         rd_dec;
`endif
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         keys_ready;
  logic         err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] key;
    string        name;
    int           age;
  } exp_t;
  exp_t sb_q[$];

  logic [127:0] ks [11];
  logic [127:0] k2;

  always #5 clk = ~clk;

  round_key_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_valid (init_valid),
    .init_key   (init_key),
    .exp_key    (exp_key),
    .exp_addr   (exp_addr),
    .exp_loaded (exp_loaded),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
`ifdef ROUND_KEY_STORE_DEC_ORDER_EN
    .rd_dec     (rd_dec),
`endif
    .rd_valid   (rd_valid),
    .rd_key     (rd_key),
    .keys_ready (keys_ready),
    .err        (err)
  );

  // Monitor: pops one expectation per rd_valid; an expectation that ages past its slot fails.
  always @(negedge clk) begin
    if (rd_valid) begin
      total = total + 1;
      if (sb_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL rd_unexpected: rd_valid=1 with no outstanding read, rd_key=%h", rd_key);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rd_key !== e.key) begin
          bad = bad + 1;
          $display("FAIL %s: rd_key=%h expected=%h", e.name, rd_key, e.key);
        end
      end
    end else if (sb_q.size() != 0) begin
      sb_q[0].age = sb_q[0].age + 1;
      if (sb_q[0].age >= 2) begin
        exp_t e;
        e = sb_q.pop_front();
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: rd_valid=0 expected=1", e.name);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got=%b expected=%b", name, got, want);
    end
  endtask

  task automatic push_rd(input logic [3:0] a, input logic [127:0] k, input string name);
    exp_t e;
    e.key  = k;
    e.name = name;
    e.age  = 0;
    sb_q.push_back(e);
    rd_req  = 1'b1;
    rd_addr = a;
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] k, input string name);
    push_rd(a, k, name);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_init(input logic [127:0] k);
    init_valid = 1'b1;
    init_key   = k;
    tick();
    init_valid = 1'b0;
  endtask

  task automatic wr(input int i);
    exp_addr = 4'(i);
    exp_key  = ks[i];
    tick();
    exp_addr = '0;
  endtask

  initial begin
    ks[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ks[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k2     = 128'h000102030405060708090a0b0c0d0e0f;

    rst_n = 1'b0; init_valid = 1'b0; init_key = '0; exp_key = '0; exp_addr = '0;
    exp_loaded = 1'b0; rd_req = 1'b0; rd_addr = '0;
`ifdef ROUND_KEY_STORE_DEC_ORDER_EN
    rd_dec = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_keys_ready", keys_ready, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_key_zero", (rd_key == '0), 1'b1);

    // Full FIPS-197 fill.
    do_init(ks[0]);
    for (int i = 1; i <= 9; i++) wr(i);
    chk("not_ready_before_10", keys_ready, 1'b0);
    wr(10);
    chk("ready_after_10", keys_ready, 1'b1);
    chk("fill_err_clear", err, 1'b0);

    // Back-to-back legal reads.
    rd(4'd1, ks[1], "rd_key1");
    rd(4'd10, ks[10], "rd_key10");
    rd(4'd0, ks[0], "rd_key0");
    rd(4'd5, ks[5], "rd_key5");
    tick();
    chk("reads_err_clear", err, 1'b0);

    // Rekey with a same-cycle read of slot 0: old key comes back.
    init_valid = 1'b1;
    init_key   = k2;
    push_rd(4'd0, ks[0], "rekey_rd_old");
    tick();
    init_valid = 1'b0;
    rd_req     = 1'b0;
    chk("rekey_ready_drop", keys_ready, 1'b0);
    for (int i = 1; i <= 10; i++) wr(i);
    chk("rekey_ready_again", keys_ready, 1'b1);
    rd(4'd0, k2, "rekey_rd_new");
    rd(4'd7, ks[7], "rekey_rd7");

    // Out-of-range read in READY.
    rd(4'd11, '0, "rd_oob_zero");
    chk("rd_oob_err", err, 1'b1);
    chk("rd_oob_still_ready", keys_ready, 1'b1);

    // Premature read while filling.
    do_init(ks[0]);
    chk("init_clears_err", err, 1'b0);
    for (int i = 1; i <= 4; i++) wr(i);
    rd(4'd5, '0, "premature_rd_zero");
    chk("premature_err", err, 1'b1);

    // Out-of-order write.
    do_init(ks[0]);
    chk("init2_clears_err", err, 1'b0);
    wr(1);
    chk("ooo_no_err_yet", err, 1'b0);
    wr(3);
    chk("ooo_err", err, 1'b1);
    wr(2);
    chk("ooo_empty_not_ready", keys_ready, 1'b0);
    rd(4'd1, '0, "empty_rd_zero");

    // Reset mid-fill, after a legal nonzero read and an exp_loaded-induced error.
    do_init(ks[0]);
    for (int i = 1; i <= 10; i++) wr(i);
    rd(4'd1, ks[1], "pre_reset_rd1");
    do_init(ks[0]);
    for (int i = 1; i <= 4; i++) wr(i);
    exp_loaded = 1'b1;
    tick();
    exp_loaded = 1'b0;
    chk("exp_loaded_err", err, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_err", err, 1'b0);
    chk("midrst_keys_ready", keys_ready, 1'b0);
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_rd_key_zero", (rd_key == '0), 1'b1);
    wr(5);
    chk("after_rst_write_err", err, 1'b1);

`ifdef ROUND_KEY_STORE_DEC_ORDER_EN
    do_init(ks[0]);
    for (int i = 1; i <= 10; i++) wr(i);
    rd_dec = 1'b1;
    rd(4'd0, ks[10], "dec_rd0");
    rd(4'd3, ks[7], "dec_rd3");
    rd(4'd11, '0, "dec_oob_zero");
    rd_dec = 1'b0;
    chk("dec_oob_err", err, 1'b1);
`endif

    tick(); tick(); tick();
    if (sb_q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: outstanding=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
